// File: rtl/mpu_dot_seq.sv
// mpu_dot_seq: dot-product sequencer that serialises a, b and the running sum
// onto a single-port FMA and accumulates its results into a final sum.
`default_nettype none

module mpu_dot_seq #(
  parameter int VEC_LEN = 255,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic [7:0]  len_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        op_valid_in,
  output logic        op_ready_out,
  output logic        fma_start_out,
  output logic [31:0] fma_float_out,
  input  logic [31:0] fma_result_in,
  input  logic        fma_ready_in,
  input  logic        fma_error_in,
  output logic [31:0] dot_out,
  output logic        dot_valid_out,
  output logic        error_out,
  output logic        busy_out
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] LEN_MAX = (VEC_LEN > 255) ? 8'd255 : 8'(VEC_LEN);

  typedef enum logic [2:0] {
    IDLE, WAIT_OP, SEND_A, SEND_B, SEND_C, WAIT_FMA, DONE, FAULT
  } state_t;

  state_t        state, next_state;
  logic [31:0]   a_q, b_q, acc;
  logic [7:0]    len_q, cnt;
  logic [TW-1:0] timer;
  logic [7:0]    len_clamped;

  // Infinity/NaN (exponent all ones) and denormals are rejected before the FMA.
  function automatic logic bad_op(input logic [31:0] x);
    return (x[30:23] == 8'hFF) || (x[30:23] == 8'h00 && x[22:0] != 23'd0);
  endfunction

  assign len_clamped = (len_in > LEN_MAX) ? LEN_MAX : len_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_in) next_state = (len_clamped == 8'd0) ? DONE : WAIT_OP;
      WAIT_OP:  if (op_valid_in) next_state = (bad_op(a_in) || bad_op(b_in)) ? FAULT : SEND_A;
      SEND_A:   next_state = SEND_B;
      SEND_B:   next_state = SEND_C;
      SEND_C:   next_state = WAIT_FMA;
      WAIT_FMA: begin
        if (fma_error_in)            next_state = FAULT;
        else if (fma_ready_in)       next_state = (cnt + 8'd1 == len_q) ? DONE : WAIT_OP;
        else if (timer == TIMER_LAST) next_state = FAULT;
      end
      DONE:     next_state = IDLE;
      FAULT:    next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      acc   <= 32'h0;
      len_q <= 8'd0;
      cnt   <= 8'd0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          len_q <= len_clamped;
          acc   <= 32'h0;
          cnt   <= 8'd0;
        end
        WAIT_OP: if (op_valid_in) begin
          a_q <= a_in;
          b_q <= b_in;
        end
        SEND_C: timer <= '0;
        WAIT_FMA: begin
          timer <= timer + TW'(1);
          if (!fma_error_in && fma_ready_in) begin
            acc <= fma_result_in;
            cnt <= cnt + 8'd1;
          end
        end
        FAULT:   acc <= 32'h0;
        default: ;
      endcase
    end
  end

  // Outputs are registered from the state register. op_ready follows the next
  // state so that it drops on the very edge that completes a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_ready_out  <= 1'b0;
      fma_start_out <= 1'b0;
      fma_float_out <= 32'h0;
      dot_out       <= 32'h0;
      dot_valid_out <= 1'b0;
      error_out     <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      op_ready_out  <= (next_state == WAIT_OP);
      fma_start_out <= (state == SEND_A);
      dot_valid_out <= (state == DONE);
      error_out     <= (state == FAULT);
      busy_out      <= (state != IDLE);
      case (state)
        SEND_A:  fma_float_out <= a_q;
        SEND_B:  fma_float_out <= b_q;
        SEND_C:  fma_float_out <= acc;
        default: fma_float_out <= 32'h0;
      endcase
      if (state == DONE) dot_out <= acc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mpu_dot_seq.sv
// tb_mpu_dot_seq: directed bench for mpu_dot_seq with a scripted FMA responder.
`default_nettype none

module tb_mpu_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [7:0]  len_in;
  logic [31:0] a_in, b_in;
  logic        op_valid_in;
  logic        op_ready_out;
  logic        fma_start_out;
  logic [31:0] fma_float_out;
  logic [31:0] fma_result_in;
  logic        fma_ready_in;
  logic        fma_error_in;
  logic [31:0] dot_out;
  logic        dot_valid_out;
  logic        error_out;
  logic        busy_out;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] F0 = 32'h00000000;
  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F6 = 32'h40C00000;
  localparam logic [31:0] F8 = 32'h41000000;
  localparam logic [31:0] INF = 32'h7F800000;

  mpu_dot_seq #(.VEC_LEN(255), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .len_in(len_in),
    .a_in(a_in), .b_in(b_in), .op_valid_in(op_valid_in), .op_ready_out(op_ready_out),
    .fma_start_out(fma_start_out), .fma_float_out(fma_float_out),
    .fma_result_in(fma_result_in), .fma_ready_in(fma_ready_in), .fma_error_in(fma_error_in),
    .dot_out(dot_out), .dot_valid_out(dot_valid_out), .error_out(error_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run(input logic [7:0] l);
    start_in = 1'b1;
    len_in   = l;
    tick();
    start_in = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input int delay);
    int n = 0;
    tick(delay);
    a_in = a; b_in = b; op_valid_in = 1'b1;
    while (!op_ready_out && n < 50) begin tick(); n++; end
    chk("op_ready_seen", {31'b0, op_ready_out}, 32'd1);
    tick();
    op_valid_in = 1'b0;
    chk("op_ready_drop", {31'b0, op_ready_out}, 32'd0);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!fma_start_out && n < 50) begin tick(); n++; end
    chk("fma_start_seen", {31'b0, fma_start_out}, 32'd1);
  endtask

  // Checks the three serialised words, then answers after lat cycles.
  task automatic fma_txn(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                         input int lat, input logic [31:0] res, input logic err, input logic rdy);
    wait_start();
    chk("busy", {31'b0, busy_out}, 32'd1);
    chk("float_a", fma_float_out, ea);
    tick();
    chk("start_pulse", {31'b0, fma_start_out}, 32'd0);
    chk("float_b", fma_float_out, eb);
    tick();
    chk("float_c", fma_float_out, ec);
    tick(lat);
    fma_result_in = res; fma_ready_in = rdy; fma_error_in = err;
    tick();
    fma_ready_in = 1'b0; fma_error_in = 1'b0;
  endtask

  task automatic expect_done(input logic [31:0] exp);
    chk("dot_valid_early", {31'b0, dot_valid_out}, 32'd0);
    tick();
    chk("dot_valid", {31'b0, dot_valid_out}, 32'd1);
    chk("dot_out", dot_out, exp);
    chk("float_idle", fma_float_out, F0);
    tick();
    chk("dot_valid_pulse", {31'b0, dot_valid_out}, 32'd0);
    chk("dot_hold", dot_out, exp);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, {31'b0, op_ready_out}, 32'd0);
    chk({tag, "_start"}, {31'b0, fma_start_out}, 32'd0);
    chk({tag, "_float"}, fma_float_out, F0);
    chk({tag, "_dot"}, dot_out, F0);
    chk({tag, "_valid"}, {31'b0, dot_valid_out}, 32'd0);
    chk({tag, "_error"}, {31'b0, error_out}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy_out}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start_in = 1'b0; len_in = 8'd0; a_in = 32'h0; b_in = 32'h0;
    op_valid_in = 1'b0; fma_result_in = 32'h0; fma_ready_in = 1'b0; fma_error_in = 1'b0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // len=1: 2.0 * 3.0 = 6.0
    start_run(8'd1);
    send_op(F2, F3, 0);
    fma_txn(F2, F3, F0, 1, F6, 1'b0, 1'b1);
    expect_done(F6);

    // len=3: (1,1),(2,1),(3,1) with varied operand delays
    start_run(8'd3);
    send_op(F1, F1, 0);
    fma_txn(F1, F1, F0, 0, F1, 1'b0, 1'b1);
    send_op(F2, F1, 2);
    fma_txn(F2, F1, F1, 2, F3, 1'b0, 1'b1);
    send_op(F3, F1, 3);
    fma_txn(F3, F1, F3, 1, F6, 1'b0, 1'b1);
    expect_done(F6);

    // len=0: immediate completion with zero sum
    start_run(8'd0);
    chk("len0_start", {31'b0, fma_start_out}, 32'd0);
    expect_done(F0);
    chk("len0_no_start", {31'b0, fma_start_out}, 32'd0);

    // +inf operand faults without touching the FMA
    start_run(8'd1);
    send_op(INF, F1, 0);
    chk("inf_err_early", {31'b0, error_out}, 32'd0);
    tick();
    chk("inf_err", {31'b0, error_out}, 32'd1);
    chk("inf_no_start", {31'b0, fma_start_out}, 32'd0);
    chk("inf_busy", {31'b0, busy_out}, 32'd1);
    tick();
    chk("inf_err_pulse", {31'b0, error_out}, 32'd0);
    chk("inf_idle", {31'b0, busy_out}, 32'd0);
    start_run(8'd1);
    send_op(F2, F3, 1);
    fma_txn(F2, F3, F0, 3, F6, 1'b0, 1'b1);
    expect_done(F6);

    // FMA never answers: fault TIMEOUT cycles after WAIT_FMA entry
    start_run(8'd1);
    send_op(F2, F3, 0);
    wait_start();
    n = 0;
    while (!error_out && n < 40) begin tick(); n++; end
    chk("timeout_cycles", 32'(n), 32'd19);
    chk("timeout_no_valid", {31'b0, dot_valid_out}, 32'd0);
    tick();

    // error and ready together: error wins, dot_out unchanged
    start_run(8'd1);
    send_op(F2, F3, 0);
    fma_txn(F2, F3, F0, 1, F8, 1'b1, 1'b1);
    tick();
    chk("err_prio", {31'b0, error_out}, 32'd1);
    chk("err_prio_valid", {31'b0, dot_valid_out}, 32'd0);
    chk("err_dot_hold", dot_out, F6);
    tick();

    // async reset during element 2's FMA wait
    start_run(8'd3);
    send_op(F1, F1, 0);
    fma_txn(F1, F1, F0, 0, F1, 1'b0, 1'b1);
    send_op(F2, F1, 0);
    wait_start();
    tick(2);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {31'b0, dot_valid_out}, 32'd0);
    chk("post_rst_error", {31'b0, error_out}, 32'd0);
    start_run(8'd1);
    send_op(F2, F3, 0);
    fma_txn(F2, F3, F0, 2, F6, 1'b0, 1'b1);
    expect_done(F6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mpu_dot_seq.md
# mpu_dot_seq

Dot-product sequencer that sits directly upstream of the `fma` stage in the MPU datapath. It accepts a stream of `(a, b)` operand pairs over a valid/ready handshake. For each pair it serialises `a`, `b` and the running sum `c` onto the FMA's single `float_in` port on three consecutive cycles. It waits for the FMA result, then feeds that result back as the next `c`. After `len` elements it presents the final sum with a one-cycle valid pulse, and it converts FMA errors, invalid operands and FMA stalls into a single error pulse.

## Interface
- `VEC_LEN`, default 255: maximum accepted vector length. `len_in` above this value is clamped to `VEC_LEN`.
- `TIMEOUT`, default 16: maximum number of cycles to wait in WAIT_FMA before faulting.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_in`  in  1  begin a dot product. Sampled only in IDLE.
- `len_in`  in  8  element count. Captured together with `start_in`.
- `a_in`, `b_in`  in  32 each  `float_sp` operand pair.
- `op_valid_in`  in  1  operand pair valid.
- `op_ready_out`  out  1  sequencer can accept an operand pair.
- `fma_start_out`  out  1  drives FMA `start_in`.
- `fma_float_out`  out  32  drives FMA `float_in`.
- `fma_result_in`  in  32  FMA `float_out`.
- `fma_ready_in`  in  1  FMA `ready_out`.
- `fma_error_in`  in  1  FMA `error_out`.
- `dot_out`  out  32  final sum. Held stable until the next `start_in` is accepted.
- `dot_valid_out`  out  1  one-cycle pulse: `dot_out` is valid.
- `error_out`  out  1  one-cycle fault pulse.
- `busy_out`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT_OP, SEND_A, SEND_B, SEND_C, WAIT_FMA, DONE, FAULT.
- IDLE, on `start_in`:
  - capture `len` (clamped); set `acc = 0`, `cnt = 0`;
  - if `len == 0`, go to DONE; otherwise go to WAIT_OP.
- WAIT_OP: `op_ready_out = 1`. On `op_valid_in`, latch `a_in` and `b_in`, then:
  - if either operand is invalid, go to FAULT; no FMA transaction is started;
  - otherwise go to SEND_A.
  - An operand is invalid when its exponent is `0xFF`, or its exponent is 0 and its mantissa is non-zero (denormal).
- SEND_A: `fma_start_out = 1`, `fma_float_out = a`. Next state SEND_B.
- SEND_B: `fma_float_out = b`. Next state SEND_C.
- SEND_C: `fma_float_out = acc`. Next state WAIT_FMA with the timer cleared.
  - On the first element `acc = +0.0`, so the FMA skips accumulation.
- WAIT_FMA: increment the timer each cycle.
  - `fma_error_in` → FAULT. This has priority over `fma_ready_in` in the same cycle.
  - `fma_ready_in` → `acc = fma_result_in`, `cnt = cnt + 1`; go to DONE if `cnt + 1 == len`, otherwise WAIT_OP.
  - Timer reaches `TIMEOUT` → FAULT.
- DONE: `dot_out = acc`, `dot_valid_out = 1`. Next state IDLE.
- FAULT: `error_out = 1`, `acc` cleared, `dot_out` unchanged. Next state IDLE.
- Driving rules:
  - `fma_float_out` is `32'h0` in every state except SEND_A/B/C. This prevents the FMA's idle-input error check from firing on stale data.
  - `fma_start_out` is high only in SEND_A.
- Ignored inputs:
  - `start_in` outside IDLE is ignored.
  - `op_valid_in` outside WAIT_OP is ignored; a held pair is not consumed.
- `cnt` and `len` are 8-bit counters; `cnt` never wraps because completion is checked before the increment.

## Timing
- All outputs are registered and decoded from the state register.
- Reset (asynchronous) forces: state IDLE, `acc`, `cnt` and timer zero, and every output 0, including `dot_out = 32'h0`.
- Asserting `rst` mid-operation aborts the operation. No `dot_valid_out` or `error_out` pulse is produced, and `fma_start_out` drops immediately.
- Per element: one WAIT_OP accept cycle, three SEND cycles, then the FMA latency (counted from the SEND_A edge to `fma_ready_in`).
- `dot_valid_out` rises one cycle after the final `fma_ready_in` is sampled.
- `len == 0`: `dot_valid_out` with `dot_out = 0` appears two cycles after `start_in`.
- The sequencer never overlaps FMA transactions; it needs exactly one FMA in flight.
- Handshake: a transfer occurs on the cycle where `op_valid_in && op_ready_out` are both high at the rising edge. `op_ready_out` drops the cycle after a transfer.

## Test plan
- `len=1`, `a=0x40000000` (2.0), `b=0x40400000` (3.0) with FMA attached → `fma_float_out` carries 0x40000000, 0x40400000, 0x00000000 on consecutive cycles; `dot_out=0x40C00000` (6.0) with a single `dot_valid_out` pulse.
- `len=3`, pairs (1,1), (2,1), (3,1) (1.0=0x3F800000), each presented with `op_valid_in` delayed 0-3 cycles → SEND_C of the three elements carries 0x0, 0x3F800000, 0x40400000; final `dot_out=0x40C00000`.
- `len=0` → `dot_valid_out` two cycles after `start_in`, `dot_out=0`, `fma_start_out` never asserted.
- Operand `a=0x7F800000` (+inf) → `error_out` pulse, no `fma_start_out`, return to IDLE; a following `len=1` run completes normally.
- FMA model that never asserts `fma_ready_in` → `error_out` exactly `TIMEOUT` cycles after entry to WAIT_FMA; `fma_error_in` and `fma_ready_in` asserted in the same cycle → FAULT.
- `rst` asserted during WAIT_FMA of element 2 → all outputs 0 asynchronously and no pulses; `start_in` after reset release is accepted.
